x_bus_issuer: RTL and testbench

X_BUS_ISSUER -- requirements
Module: x_bus_issuer

---
 rtl/x_bus_issuer_pkg.sv | 14 +
 rtl/xbi_fifo.sv | 70 +++++++
 rtl/x_bus_issuer.sv | 163 ++++++++++++++++
 tb/tb_x_bus_issuer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/x_bus_issuer_pkg.sv
// Shared widths and FSM state type for the X bus issuer.
package x_bus_issuer_pkg;

  localparam int unsigned TAG_W  = 9;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StStall
  } state_e;

endpackage

// File: rtl/xbi_fifo.sv
// Small synchronous FIFO feeding the X bus issuer.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   flush_i       - synchronous clear; overrides push and pop
//   push_i        - write wdata_i (caller guarantees not full)
//   pop_i         - drop head entry (caller guarantees not empty)
//   head_o        - current head entry
//   head_valid_o  - FIFO non-empty
//   count_o       - number of stored entries
module xbi_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 41,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] head_o,
  output logic             head_valid_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d;
  logic [PtrW-1:0]  rd_q, rd_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (push_i) wr_d = wr_q + PtrW'(1);
      if (pop_i)  rd_d = rd_q + PtrW'(1);
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign head_o       = mem_q[rd_q];
  assign head_valid_o = (count_q != '0);
  assign count_o      = count_q;

endmodule

// File: rtl/x_bus_issuer.sv
// X bus issuer: queues tagged items and multicasts each one atomically to every
// column controller whose ID matches the tag. Items matching no column are dropped
// and counted; a head blocked for TIMEOUT cycles raises a sticky stall error.
// Ports:
//   clk, rst                       - clock, asynchronous active-low reset
//   in_valid/in_ready/in_tag/in_value - upstream push interface
//   col_id, col_ready              - per-column ID (9 bits each) and ready
//   bus_enable/bus_tag/bus_value   - bus transfer strobe and payload (0 when idle)
//   flush                          - synchronous clear of queued work and stall error
//   busy, stall_err, drop_cnt      - status
module x_bus_issuer
  import x_bus_issuer_pkg::*;
#(
  parameter int unsigned NCOL    = 12,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic [DATA_W-1:0]     in_value,
  input  logic [NCOL*TAG_W-1:0] col_id,
  input  logic [NCOL-1:0]       col_ready,
  output logic                  bus_enable,
  output logic [TAG_W-1:0]      bus_tag,
  output logic [DATA_W-1:0]     bus_value,
  input  logic                  flush,
  output logic                  busy,
  output logic                  stall_err,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam int unsigned EntW  = TAG_W + DATA_W;

  logic [EntW-1:0]   head;
  logic              head_valid;
  logic [CntW-1:0]   fifo_count;
  logic [TAG_W-1:0]  head_tag;
  logic [DATA_W-1:0] head_value;

  logic [NCOL-1:0] match;
  logic            any_match, all_ok;
  logic            fire, drop, blocked, push, pop, last_pop, reach_timeout;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             stall_err_q, stall_err_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  assign head_tag   = head[EntW-1:DATA_W];
  assign head_value = head[DATA_W-1:0];

  assign in_ready = (fifo_count < CntW'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;

  xbi_fifo #(
    .Depth (DEPTH),
    .Width (EntW),
    .CntW  (CntW)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .push_i       (push),
    .pop_i        (pop),
    .wdata_i      ({in_tag, in_value}),
    .head_o       (head),
    .head_valid_o (head_valid),
    .count_o      (fifo_count)
  );

  // Live comparison against col_id so ID changes take effect immediately.
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NCOL; i++) begin
      match[i] = (col_id[TAG_W*i +: TAG_W] == head_tag);
    end
  end

  assign any_match = |match;
  // Non-matching columns are don't-care for readiness.
  assign all_ok    = &(col_ready | ~match);

  assign fire     = head_valid && any_match && all_ok && !flush;
  assign drop     = head_valid && !any_match && !flush;
  assign blocked  = head_valid && any_match && !all_ok;
  assign pop      = fire || drop;
  assign last_pop = pop && !push && (fifo_count == CntW'(1));

  assign bus_enable = fire;
  assign bus_tag    = fire ? head_tag   : '0;
  assign bus_value  = fire ? head_value : '0;

  always_comb begin
    wait_cnt_d = '0;
    if (!flush && !pop && blocked) begin
      wait_cnt_d = (wait_cnt_q == WaitW'(TIMEOUT)) ? wait_cnt_q : wait_cnt_q + WaitW'(1);
    end
  end

  // Only a fresh arrival at TIMEOUT triggers the transition; STALL ignores it.
  assign reach_timeout = blocked && (wait_cnt_d == WaitW'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    stall_err_d = stall_err_q;
    drop_cnt_d  = drop_cnt_q;
    if (drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    if (flush) begin
      state_d     = StIdle;
      stall_err_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // An item that pops in its first head cycle never leaves IDLE.
          if (head_valid && !last_pop) begin
            if (reach_timeout) begin
              state_d     = StStall;
              stall_err_d = 1'b1;
            end else begin
              state_d = StIssue;
            end
          end
        end
        StIssue: begin
          if (reach_timeout) begin
            state_d     = StStall;
            stall_err_d = 1'b1;
          end else if (last_pop) begin
            state_d = StIdle;
          end
        end
        StStall: begin
          if (pop) state_d = last_pop ? StIdle : StIssue;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      stall_err_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_err_q <= stall_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign stall_err = stall_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_x_bus_issuer.sv
module tb_x_bus_issuer;
  import x_bus_issuer_pkg::*;

  localparam int unsigned NCOL = 12;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [8:0]            in_tag;
  logic [31:0]           in_value;
  logic [NCOL*9-1:0]     col_id;
  logic [NCOL-1:0]       col_ready;
  logic                  bus_enable;
  logic [8:0]            bus_tag;
  logic [31:0]           bus_value;
  logic                  flush;
  logic                  busy;
  logic                  stall_err;
  logic [15:0]           drop_cnt;

  typedef struct packed {
    logic [8:0]  tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;

  x_bus_issuer #(
    .NCOL    (NCOL),
    .DEPTH   (4),
    .TIMEOUT (255)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_tag     (in_tag),
    .in_value   (in_value),
    .col_id     (col_id),
    .col_ready  (col_ready),
    .bus_enable (bus_enable),
    .bus_tag    (bus_tag),
    .bus_value  (bus_value),
    .flush      (flush),
    .busy       (busy),
    .stall_err  (stall_err),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: every bus transfer must match the oldest expected item.
  always @(negedge clk) begin
    if (rst && bus_enable) begin
      checks++;
      if (sbq.size() == 0) begin
        $display("FAIL sb_unexpected: got bus tag %0h value %0h, expected no transfer",
                 bus_tag, bus_value);
      end else begin
        mon_e = sbq.pop_front();
        if ({bus_tag, bus_value} !== {mon_e.tag, mon_e.val})
          $display("FAIL sb_order: got %0h/%0h expected %0h/%0h",
                   bus_tag, bus_value, mon_e.tag, mon_e.val);
        else passed++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ids_default();
    for (int i = 0; i < NCOL; i++) col_id[9*i +: 9] = 9'(i);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (bus_enable !== 1'b0) $display("FAIL rst_bus_en: got %b want 0", bus_enable); else passed++;
    checks++; if ({bus_tag, bus_value} !== 41'd0) $display("FAIL rst_bus_data: got %0h want 0", {bus_tag, bus_value}); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    checks++; if ({stall_err, drop_cnt} !== 17'd0) $display("FAIL rst_status: got %0h want 0", {stall_err, drop_cnt}); else passed++;
    step();
    rst = 1'b1;
  endtask

  task automatic test_basic();
    step();
    set_ids_default();
    col_ready = '1;
    in_valid = 1'b1; in_tag = 9'd5; in_value = 32'hA5A5A5A5;
    sbq.push_back('{tag: 9'd5, val: 32'hA5A5A5A5});
    @(negedge clk);
    checks++; if (bus_enable !== 1'b0) $display("FAIL basic_pre: got %b want 0", bus_enable); else passed++;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus_enable !== 1'b1) $display("FAIL basic_en: got %b want 1", bus_enable); else passed++;
    checks++; if (bus_tag !== 9'd5) $display("FAIL basic_tag: got %0h want 5", bus_tag); else passed++;
    checks++; if (bus_value !== 32'hA5A5A5A5) $display("FAIL basic_value: got %0h want a5a5a5a5", bus_value); else passed++;
    step();
    @(negedge clk);
    checks++; if (bus_enable !== 1'b0) $display("FAIL basic_once: got %b want 0", bus_enable); else passed++;
    checks++; if ({bus_tag, bus_value} !== 41'd0) $display("FAIL basic_idle_data: got %0h want 0", {bus_tag, bus_value}); else passed++;
  endtask

  task automatic test_multicast();
    step();
    for (int i = 0; i < NCOL; i++) col_id[9*i +: 9] = 9'(20 + i);
    col_id[9*2 +: 9] = 9'd3;
    col_id[9*7 +: 9] = 9'd3;
    col_ready = '1;
    col_ready[7] = 1'b0;
    col_ready[0] = 1'b0;  // non-matching column must not block
    in_valid = 1'b1; in_tag = 9'd3; in_value = 32'h12345678;
    sbq.push_back('{tag: 9'd3, val: 32'h12345678});
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (bus_enable !== 1'b0) $display("FAIL mc_blocked_%0d: got %b want 0", k, bus_enable); else passed++;
      step();
    end
    col_ready[7] = 1'b1;
    @(negedge clk);
    checks++; if (bus_enable !== 1'b1) $display("FAIL mc_fire: got %b want 1", bus_enable); else passed++;
    checks++; if (bus_tag !== 9'd3) $display("FAIL mc_tag: got %0h want 3", bus_tag); else passed++;
    step();
    @(negedge clk);
    checks++; if (bus_enable !== 1'b0) $display("FAIL mc_once: got %b want 0", bus_enable); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mc_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_drop();
    step();
    set_ids_default();
    col_ready = '1;
    in_valid = 1'b1; in_tag = 9'h1FF; in_value = 32'hDEAD0001;
    @(negedge clk);
    checks++; if (drop_cnt !== 16'd0) $display("FAIL drop_pre: got %0d want 0", drop_cnt); else passed++;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus_enable !== 1'b0) $display("FAIL drop_no_en: got %b want 0", bus_enable); else passed++;
    step();
    @(negedge clk);
    checks++; if (drop_cnt !== 16'd1) $display("FAIL drop_cnt: got %0d want 1", drop_cnt); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b want 0", busy); else passed++;
    checks++; if (dut.fifo_count !== 3'd0) $display("FAIL drop_empty: got %0d want 0", dut.fifo_count); else passed++;
    step();
    @(negedge clk);
    checks++; if (drop_cnt !== 16'd1) $display("FAIL drop_single: got %0d want 1", drop_cnt); else passed++;
  endtask

  task automatic test_stall();
    logic seen_en;
    seen_en = 1'b0;
    step();
    set_ids_default();
    col_ready = '1;
    col_ready[5] = 1'b0;
    in_valid = 1'b1; in_tag = 9'd5; in_value = 32'hDEADBEEF;
    sbq.push_back('{tag: 9'd5, val: 32'hDEADBEEF});
    step();
    in_valid = 1'b0;
    // Cycle k is the k-th blocked cycle; stall_err is visible once 255 have elapsed.
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus_enable) seen_en = 1'b1;
      if (k == 255) begin
        checks++; if (stall_err !== 1'b0) $display("FAIL stall_early: got %b want 0", stall_err); else passed++;
      end
      if (k == 256) begin
        checks++; if (stall_err !== 1'b1) $display("FAIL stall_set: got %b want 1", stall_err); else passed++;
        checks++; if (dut.state_q !== StStall) $display("FAIL stall_state: got %0d want %0d", dut.state_q, StStall); else passed++;
      end
      step();
    end
    checks++; if (seen_en !== 1'b0) $display("FAIL stall_no_en: got %b want 0", seen_en); else passed++;
    col_ready[5] = 1'b1;
    @(negedge clk);
    checks++; if (bus_enable !== 1'b1) $display("FAIL stall_fire: got %b want 1", bus_enable); else passed++;
    step();
    @(negedge clk);
    checks++; if (bus_enable !== 1'b0) $display("FAIL stall_once: got %b want 0", bus_enable); else passed++;
    checks++; if (stall_err !== 1'b1) $display("FAIL stall_sticky: got %b want 1", stall_err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL stall_idle: got %b want 0", busy); else passed++;
  endtask

  task automatic test_flush();
    step();
    set_ids_default();
    col_ready = '0;
    in_valid = 1'b1; in_tag = 9'd5;
    for (int k = 0; k < 5; k++) begin
      in_value = 32'(k);
      @(negedge clk);
      checks++; if (in_ready !== (k < 4)) $display("FAIL flush_fill_%0d: got %b want %b", k, in_ready, (k < 4)); else passed++;
      step();
    end
    flush = 1'b1;
    col_ready = '1;  // head would fire here if flush did not win
    @(negedge clk);
    checks++; if (bus_enable !== 1'b0) $display("FAIL flush_no_en: got %b want 0", bus_enable); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready); else passed++;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (dut.fifo_count !== 3'd0) $display("FAIL flush_count: got %0d want 0", dut.fifo_count); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", in_ready); else passed++;
    checks++; if (stall_err !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall_err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy); else passed++;
    checks++; if (drop_cnt !== 16'd1) $display("FAIL flush_drop_cnt: got %0d want 1", drop_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] tags [5];
    tags[0] = 9'd0; tags[1] = 9'd1; tags[2] = 9'h100; tags[3] = 9'd2; tags[4] = 9'd11;
    step();
    set_ids_default();
    col_ready = '1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_tag   = tags[k];
      in_value = $urandom();
      if (tags[k] < 9'd12) sbq.push_back('{tag: in_tag, val: in_value});
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", k, in_ready); else passed++;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks++; if (drop_cnt !== 16'd2) $display("FAIL b2b_drop_cnt: got %0d want 2", drop_cnt); else passed++;
    checks++; if (sbq.size() != 0) $display("FAIL b2b_drain: got %0d pending want 0", sbq.size()); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL b2b_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid();
    logic seen_en;
    seen_en = 1'b0;
    step();
    set_ids_default();
    col_ready = '0;
    in_valid = 1'b1; in_tag = 9'd5;
    for (int k = 0; k < 3; k++) begin
      in_value = 32'hC0DE0000 + 32'(k);
      step();
    end
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    col_ready = '1;
    #1;
    checks++; if (dut.fifo_count !== 3'd0) $display("FAIL rmid_count: got %0d want 0", dut.fifo_count); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", in_ready); else passed++;
    checks++; if (bus_enable !== 1'b0) $display("FAIL rmid_en: got %b want 0", bus_enable); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else passed++;
    checks++; if (drop_cnt !== 16'd0) $display("FAIL rmid_drop_cnt: got %0d want 0", drop_cnt); else passed++;
    step();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus_enable) seen_en = 1'b1;
      step();
    end
    checks++; if (seen_en !== 1'b0) $display("FAIL rmid_bus_idle: got %b want 0", seen_en); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rmid_ready_after: got %b want 1", in_ready); else passed++;
    checks++; if (drop_cnt !== 16'd0) $display("FAIL rmid_drop_after: got %0d want 0", drop_cnt); else passed++;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_tag = '0;
    in_value = '0;
    col_id = '0;
    col_ready = '0;
    flush = 1'b0;
    test_reset();
    test_basic();
    test_multicast();
    test_drop();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    checks++; if (sbq.size() != 0) $display("FAIL sb_leftover: got %0d pending want 0", sbq.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
